spi_mem_loader: RTL and testbench

- SPI slave front end that turns serial frames from the external SPI master into word writes on the core's instruction/data memory port, so the host can preload program images before fetch is enabled.
- Sits between the top-level SPI pins and the memory interconnect of top_core.
- Oversamples SCLK and CS in the system clock domain; no second clock.
- Implements quad-less single-lane mode 0: sdi0 in, sdo0 out, MSB first.

---
 rtl/spi_mem_loader.sv | 265 ++++++++++++++++++++++++++
 tb/tb_spi_mem_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_loader.sv
// Mode-0 SPI slave that turns host frames {cmd, addr, data} into word writes on the memory port.
// Define SPI_MEM_LOADER_READBACK_EN to add the single-word read command with dummy cycles.
module spi_mem_loader #(
   parameter int         ADDR_W    = 32,
   parameter int         DATA_W    = 32,
   parameter logic [7:0] CMD_WRITE = 8'h02,
   parameter logic [7:0] CMD_READ  = 8'h0B,
   parameter int         DUMMY_CYC = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              spi_sclk,
   input  logic              spi_cs,
   input  logic              spi_sdi0,
   output logic              spi_sdo0,
   output logic              mem_req_o,
   input  logic              mem_gnt_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [3:0]        mem_be_o,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_rvalid_i,
   output logic              busy_o,
   output logic [15:0]       wr_cnt_o,
   output logic              err_o
);
   localparam int SH_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

`ifdef SPI_MEM_LOADER_READBACK_EN
   typedef enum logic [3:0] {IDLE, CMD, ADDR, DATA, REQ, WAIT, IGNORE, DUMMY, RESP} state_e;
`else
   typedef enum logic [3:0] {IDLE, CMD, ADDR, DATA, REQ, WAIT, IGNORE} state_e;
`endif

   state_e            state_q;
   logic [2:0]        sclk_q;
   logic [2:0]        cs_q;
   logic [1:0]        sdi_q;
   logic [5:0]        bit_cnt_q;
   logic [SH_W-1:0]   shift_q;
   logic [SH_W-1:0]   shift_d;
   logic              mem_req_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [15:0]       wr_cnt_q;
   logic              err_q;
   logic              sclk_rise;
   logic              sclk_fall;
   logic              cs_fall;
   logic              cs_hi;
   logic              unused_s;

`ifdef SPI_MEM_LOADER_READBACK_EN
   logic              rd_q;
   logic              rvld_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] tx_q;
   logic              sdo_q;
   assign spi_sdo0 = sdo_q;
   assign unused_s = shift_q[SH_W-1];
`else
   assign spi_sdo0 = 1'b0;
   assign unused_s = ^{mem_rdata_i, mem_rvalid_i, shift_q[SH_W-1], sclk_fall, CMD_READ, DUMMY_CYC};
`endif

   // Synchronizers idle at sclk low and cs deasserted; sclk and cs keep one extra stage for edges.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_q <= 3'b000;
         cs_q   <= 3'b111;
         sdi_q  <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], spi_sclk};
         cs_q   <= {cs_q[1:0], spi_cs};
         sdi_q  <= {sdi_q[0], spi_sdi0};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_fall   = cs_q[2] & ~cs_q[1];
   assign cs_hi     = cs_q[1];
   assign shift_d   = {shift_q[SH_W-2:0], sdi_q[1]};

   // Frame sequencer with registered memory-port outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         bit_cnt_q   <= 6'd0;
         shift_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wr_cnt_q    <= 16'd0;
         err_q       <= 1'b0;
`ifdef SPI_MEM_LOADER_READBACK_EN
         rd_q        <= 1'b0;
         rvld_q      <= 1'b0;
         rdata_q     <= '0;
         tx_q        <= '0;
         sdo_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (cs_fall) begin
                  state_q   <= CMD;
                  bit_cnt_q <= 6'd0;
               end
            end
            CMD: begin
               if (cs_hi) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  shift_q <= shift_d;
                  if (bit_cnt_q == 6'd7) begin
                     bit_cnt_q <= 6'd0;
                     if (shift_d[7:0] == CMD_WRITE) begin
                        state_q <= ADDR;
`ifdef SPI_MEM_LOADER_READBACK_EN
                        rd_q    <= 1'b0;
                     end else if (shift_d[7:0] == CMD_READ) begin
                        state_q <= ADDR;
                        rd_q    <= 1'b1;
`endif
                     end else begin
                        err_q   <= 1'b1;
                        state_q <= IGNORE;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                  end
               end
            end
            ADDR: begin
               if (cs_hi) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  shift_q <= shift_d;
                  if (bit_cnt_q == 6'(ADDR_W - 1)) begin
                     bit_cnt_q  <= 6'd0;
                     mem_addr_q <= {shift_d[ADDR_W-1:2], 2'b00};
`ifdef SPI_MEM_LOADER_READBACK_EN
                     if (rd_q) begin
                        state_q   <= REQ;
                        mem_req_q <= 1'b1;
                        mem_we_q  <= 1'b0;
                        rvld_q    <= 1'b0;
                     end else begin
                        state_q <= DATA;
                     end
`else
                     state_q <= DATA;
`endif
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                  end
               end
            end
            DATA: begin
               if (cs_hi) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  shift_q <= shift_d;
                  if (bit_cnt_q == 6'(DATA_W - 1)) begin
                     bit_cnt_q   <= 6'd0;
                     state_q     <= REQ;
                     mem_req_q   <= 1'b1;
                     mem_we_q    <= 1'b1;
                     mem_wdata_q <= shift_d[DATA_W-1:0];
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                  end
               end
            end
            REQ: begin
               // A request is never abandoned: CS activity is ignored until the grant.
               if (mem_gnt_i) begin
                  mem_req_q <= 1'b0;
                  if (mem_we_q) begin
                     state_q <= WAIT;
                     if (wr_cnt_q != 16'hFFFF) begin
                        wr_cnt_q <= wr_cnt_q + 16'd1;
                     end
                  end else begin
`ifdef SPI_MEM_LOADER_READBACK_EN
                     state_q <= DUMMY;
`else
                     state_q <= WAIT;
`endif
                  end
               end
`ifdef SPI_MEM_LOADER_READBACK_EN
               if (!mem_we_q && sclk_rise) begin
                  bit_cnt_q <= bit_cnt_q + 6'd1;
               end
`endif
            end
            WAIT: begin
               if (cs_hi) begin
                  state_q <= IDLE;
               end
            end
            IGNORE: begin
               if (cs_hi) begin
                  state_q <= IDLE;
               end
            end
`ifdef SPI_MEM_LOADER_READBACK_EN
            DUMMY: begin
               if (mem_rvalid_i && !rvld_q) begin
                  rvld_q  <= 1'b1;
                  rdata_q <= mem_rdata_i;
               end
               if (cs_hi) begin
                  state_q <= IDLE;
               end else if (sclk_rise) begin
                  if (bit_cnt_q >= 6'(DUMMY_CYC - 1)) begin
                     bit_cnt_q <= 6'd0;
                     state_q   <= RESP;
                     tx_q      <= rvld_q ? rdata_q : DATA_W'(32'hDEADBEEF);
                     if (!rvld_q) begin
                        err_q <= 1'b1;
                     end
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 6'd1;
                  end
               end
            end
            RESP: begin
               if (cs_hi) begin
                  state_q <= IDLE;
               end else if (sclk_fall) begin
                  sdo_q     <= tx_q[DATA_W-1];
                  tx_q      <= {tx_q[DATA_W-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 6'd1;
                  if (bit_cnt_q == 6'(DATA_W - 1)) begin
                     state_q <= WAIT;
                  end
               end
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_be_o    = 4'hF;
   assign busy_o      = (state_q != IDLE);
   assign wr_cnt_o    = wr_cnt_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_spi_mem_loader.sv
// Directed bench for spi_mem_loader: host SPI driver, grant/rvalid responder and hand-computed checks.
module tb_spi_mem_loader;
   localparam int HALF = 80;
   localparam int GAP  = 1600;

   logic        clk = 1'b0;
   logic        rst;
   logic        spi_sclk, spi_cs, spi_sdi0, spi_sdo0;
   logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic [3:0]  mem_be_o;
   logic        busy_o, err_o;
   logic [15:0] wr_cnt_o;

   always #5 clk = ~clk;

   spi_mem_loader dut (
      .clk_i(clk), .rst_i(rst),
      .spi_sclk(spi_sclk), .spi_cs(spi_cs), .spi_sdi0(spi_sdi0), .spi_sdo0(spi_sdo0),
      .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
      .busy_o(busy_o), .wr_cnt_o(wr_cnt_o), .err_o(err_o)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   logic [31:0] log_addr[$];
   logic [31:0] log_data[$];
   logic [31:0] mem_model [logic [31:0]];
   int          gnt_delay  = 0;
   int          wait_cnt   = 0;
   int          req_pulses = 0;
   int          stall_bad  = 0;
   int          rd_timer   = 0;
   bit          hold_gnt   = 1'b0;
   logic [31:0] first_addr = 32'h0;
   logic [31:0] first_data = 32'h0;
   logic        first_we   = 1'b0;

   // Memory responder: grants after gnt_delay stalled cycles, logs writes, returns read data.
   initial begin
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = 32'h0;
      forever begin
         @(negedge clk);
         mem_rvalid_i = 1'b0;
         if (rd_timer > 0) begin
            rd_timer--;
            if (rd_timer == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = mem_model.exists(first_addr) ? mem_model[first_addr] : 32'h0;
            end
         end
         if (rst) begin
            mem_gnt_i = 1'b0;
            wait_cnt  = 0;
         end else if (mem_req_o && !mem_gnt_i) begin
            if (wait_cnt == 0) begin
               first_addr = mem_addr_o;
               first_data = mem_wdata_o;
               first_we   = mem_we_o;
               req_pulses++;
            end else if (mem_addr_o !== first_addr || mem_wdata_o !== first_data || mem_we_o !== first_we) begin
               stall_bad++;
            end
            if (!hold_gnt && wait_cnt >= gnt_delay) begin
               mem_gnt_i = 1'b1;
               wait_cnt  = 0;
               if (mem_we_o) begin
                  log_addr.push_back(mem_addr_o);
                  log_data.push_back(mem_wdata_o);
                  mem_model[mem_addr_o] = mem_wdata_o;
               end else begin
                  rd_timer = 2;
               end
            end else begin
               wait_cnt++;
            end
         end else begin
            mem_gnt_i = 1'b0;
         end
      end
   end

   task automatic spi_xfer(input logic [103:0] bits, input int nbits, output logic [31:0] rx);
      rx = 32'h0;
      @(negedge clk);
      spi_cs = 1'b0;
      #(HALF);
      for (int i = nbits - 1; i >= 0; i--) begin
         spi_sdi0 = bits[i];
         #(HALF);
         rx = {rx[30:0], spi_sdo0};
         spi_sclk = 1'b1;
         #(HALF);
         spi_sclk = 1'b0;
      end
      #(HALF);
      spi_cs = 1'b1;
   endtask

   task automatic write_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
      logic [103:0] bits;
      logic [31:0]  rx;
      bits = {32'h0, cmd, addr, data};
      spi_xfer(bits, 72, rx);
   endtask

   initial begin
      logic [31:0]  rx;
      logic [103:0] bits;
      int           lat;
      int           exp_wr;

      rst = 1'b1; spi_sclk = 1'b0; spi_cs = 1'b1; spi_sdi0 = 1'b0;
      repeat (4) @(negedge clk);
      check_eq("rst_req",   32'(mem_req_o), 32'h0);
      check_eq("rst_we",    32'(mem_we_o), 32'h0);
      check_eq("rst_addr",  mem_addr_o, 32'h0);
      check_eq("rst_wdata", mem_wdata_o, 32'h0);
      check_eq("rst_sdo",   32'(spi_sdo0), 32'h0);
      check_eq("rst_busy",  32'(busy_o), 32'h0);
      check_eq("rst_wrcnt", 32'(wr_cnt_o), 32'h0);
      check_eq("rst_err",   32'(err_o), 32'h0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Single write, immediate grant
      write_frame(8'h02, 32'h80, 32'h00000fff);
      #(GAP);
      check_eq("w1_pulses", 32'(req_pulses), 32'd1);
      check_eq("w1_we",     32'(first_we), 32'h1);
      check_eq("w1_addr",   log_addr[0], 32'h80);
      check_eq("w1_data",   log_data[0], 32'h00000fff);
      check_eq("w1_be",     32'(mem_be_o), 32'hF);
      check_eq("w1_wrcnt",  32'(wr_cnt_o), 32'd1);
      check_eq("w1_err",    32'(err_o), 32'h0);
      check_eq("w1_busy",   32'(busy_o), 32'h0);

      // 32 frames with a 3-cycle grant stall each
      gnt_delay = 3;
      for (int i = 0; i < 32; i++) begin
         write_frame(8'h02, 32'h80 + 32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0001_0101);
         #(GAP);
      end
      check_eq("b2b_wrcnt",  32'(wr_cnt_o), 32'd33);
      check_eq("b2b_pulses", 32'(req_pulses), 32'd33);
      check_eq("b2b_stall",  32'(stall_bad), 32'd0);
      for (int i = 0; i < 32; i++) begin
         check_eq("b2b_addr", log_addr[i + 1], 32'h80 + 32'(4 * i));
         check_eq("b2b_data", log_data[i + 1], 32'h1000_0000 + 32'(i) * 32'h0001_0101);
      end

      // Unknown opcode, then a write with low address bits set
      gnt_delay = 0;
      write_frame(8'h55, 32'h84, 32'h1);
      #(GAP);
      check_eq("bad_pulses", 32'(req_pulses), 32'd33);
      check_eq("bad_err",    32'(err_o), 32'h1);
      check_eq("bad_busy",   32'(busy_o), 32'h0);
      write_frame(8'h02, 32'h203, 32'hCAFE0001);
      #(GAP);
      check_eq("after_pulses", 32'(req_pulses), 32'd34);
      check_eq("after_addr",   log_addr[33], 32'h200);
      check_eq("after_data",   log_data[33], 32'hCAFE0001);
      check_eq("after_wrcnt",  32'(wr_cnt_o), 32'd34);

      // Reset while a request is stalled
      hold_gnt = 1'b1;
      write_frame(8'h02, 32'h300, 32'h12345678);
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (mem_req_o) break;
      end
      check_eq("stall_req",  32'(mem_req_o), 32'h1);
      check_eq("stall_addr", mem_addr_o, 32'h300);
      repeat (5) @(negedge clk);
      check_eq("stall_hold", 32'(mem_req_o), 32'h1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rreq_req",   32'(mem_req_o), 32'h0);
      check_eq("rreq_wrcnt", 32'(wr_cnt_o), 32'd0);
      check_eq("rreq_err",   32'(err_o), 32'h0);
      check_eq("rreq_busy",  32'(busy_o), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      hold_gnt = 1'b0;
      repeat (4) @(negedge clk);
      exp_wr = 0;

`ifdef SPI_MEM_LOADER_READBACK_EN
      write_frame(8'h02, 32'h100, 32'hA5A51234);
      #(GAP);
      bits = {8'h0B, 32'h100, 64'h0};
      spi_xfer(bits, 104, rx);
      #(GAP);
      check_eq("rb_data",  rx, 32'hA5A51234);
      check_eq("rb_err",   32'(err_o), 32'h0);
      check_eq("rb_wrcnt", 32'(wr_cnt_o), 32'd1);
      exp_wr = 1;
`endif

      // CS raised after 20 address bits
      lat = 99;
      bits = '0;
      bits[27:0] = {8'h02, 20'h00012};
      spi_xfer(bits, 28, rx);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         #1;
         if (!busy_o) begin
            lat = k;
            break;
         end
      end
      check_eq("abort_busy_lat", 32'(lat <= 4), 32'h1);
      check_eq("abort_err",      32'(err_o), 32'h1);
      check_eq("abort_req",      32'(mem_req_o), 32'h0);
      #(GAP);
      check_eq("abort_wrcnt",    32'(wr_cnt_o), 32'(exp_wr));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
